// File: rtl/mp_fifo_pkg.sv
// Shared helpers for the multi-port FIFO: lane-enable counting and contiguity checks.
package mp_fifo_pkg;

    // Widest enable vector the helpers accept; callers zero-extend narrower vectors.
    localparam int MAX_LANES = 16;

    function automatic int popcount_contig(input logic [MAX_LANES-1:0] v);
        int  n;
        logic run;
        n   = 0;
        run = 1'b1;
        for (int i = 0; i < MAX_LANES; i++) begin
            run = run & v[i];
            if (run) n++;
        end
        return n;
    endfunction

    // True when the set bits form an unbroken run starting at bit 0 (including all-zero).
    function automatic logic is_contig(input logic [MAX_LANES-1:0] v);
        logic [MAX_LANES-1:0] nxt;
        nxt = v + 1'b1;
        return (v & nxt) == '0;
    endfunction

endpackage

// File: rtl/mp_fifo_if.sv
// Producer/consumer bundle for mp_fifo; the FIFO takes the slave modport.
interface mp_fifo_if #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 8,
    parameter int NUM_PUSH = 2,
    parameter int NUM_POP  = 2
);
    localparam int CW = $clog2(DEPTH + 1);

    logic                      flush;
    logic [NUM_PUSH-1:0]       push_en;
    logic [NUM_PUSH*WIDTH-1:0] push_data;
    logic [NUM_PUSH-1:0]       push_ready;
    logic [NUM_POP-1:0]        pop_en;
    logic [NUM_POP*WIDTH-1:0]  pop_data;
    logic [NUM_POP-1:0]        pop_valid;
    logic [CW-1:0]             count;
    logic                      err;

    modport master (
        output flush, push_en, push_data, pop_en,
        input  push_ready, pop_data, pop_valid, count, err
    );

    modport slave (
        input  flush, push_en, push_data, pop_en,
        output push_ready, pop_data, pop_valid, count, err
    );
endinterface

// File: rtl/mp_fifo_lane_mask.sv
// Thermometer mask: lane i is set while value exceeds i.
module lane_mask #(
    parameter int N  = 2,
    parameter int VW = 4
) (
    input  logic [VW-1:0] i_value,
    output logic [N-1:0]  o_mask
);
    always_comb begin
        for (int i = 0; i < N; i++) begin
            o_mask[i] = int'(i_value) > i;
        end
    end
endmodule

// File: rtl/mp_fifo.sv
// Multi-port circular-buffer FIFO with occupancy-based ready/valid lanes and synchronous flush.
// Optional sticky protocol-error flag enabled by defining MP_FIFO_ERR_EN.
module mp_fifo
    import mp_fifo_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 8,
    parameter int NUM_PUSH = 2,
    parameter int NUM_POP  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    mp_fifo_if.slave    bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]    r_mem [DEPTH];
    logic [PW-1:0]       r_head;
    logic [PW-1:0]       r_tail;
    logic [CW-1:0]       r_count;

    logic [CW-1:0]       w_free;
    logic [NUM_PUSH-1:0] w_push_ready;
    logic [NUM_POP-1:0]  w_pop_valid;
    logic [NUM_PUSH-1:0] w_push_acc;
    logic [NUM_POP-1:0]  w_pop_acc;
    logic [CW-1:0]       w_npush;
    logic [CW-1:0]       w_npop;
    logic [PW-1:0]       w_slot [NUM_PUSH];

    assign w_free = CW'(DEPTH) - r_count;

    lane_mask #(.N(NUM_PUSH), .VW(CW)) u_push_mask (.i_value(w_free),  .o_mask(w_push_ready));
    lane_mask #(.N(NUM_POP),  .VW(CW)) u_pop_mask  (.i_value(r_count), .o_mask(w_pop_valid));

    assign w_push_acc = bus.push_en & w_push_ready;
    assign w_pop_acc  = bus.pop_en  & w_pop_valid;

    // Accepted push lanes are packed into consecutive slots in lane order, so a stray gap
    // in push_en never leaves a hole in the buffer.
    // NOTE: blocking '=' is correct here; the running count is read back within the same pass.
    always_comb begin
        w_npush = '0;
        for (int i = 0; i < NUM_PUSH; i++) begin
            w_slot[i] = r_tail + PW'(w_npush);
            if (w_push_acc[i]) w_npush = w_npush + 1'b1;
        end
    end

    always_comb begin
        w_npop = '0;
        for (int i = 0; i < NUM_POP; i++) begin
            if (w_pop_acc[i]) w_npop = w_npop + 1'b1;
        end
    end

    // NOTE: the storage array has no reset; the count alone decides which slots hold data.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_PUSH; i++) begin
            if (w_push_acc[i] && !bus.flush) r_mem[w_slot[i]] <= bus.push_data[i*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (bus.flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_tail  <= r_tail + PW'(w_npush);
            r_head  <= r_head + PW'(w_npop);
            r_count <= r_count + w_npush - w_npop;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_POP; i++) begin
            bus.pop_data[i*WIDTH +: WIDTH] = r_mem[r_head + PW'(i)];
        end
    end

    assign bus.push_ready = w_push_ready;
    assign bus.pop_valid  = w_pop_valid;
    assign bus.count      = r_count;

`ifdef MP_FIFO_ERR_EN
    logic r_err;
    logic w_err_now;

    assign w_err_now = (|(bus.push_en & ~w_push_ready))
                     | (|(bus.pop_en & ~w_pop_valid))
                     | ~is_contig(MAX_LANES'(bus.push_en))
                     | ~is_contig(MAX_LANES'(bus.pop_en));

    // Sticky until reset; flush deliberately leaves it set so a squash cannot hide a violation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         r_err <= 1'b0;
        else if (w_err_now) r_err <= 1'b1;
    end

    assign bus.err = r_err;
`else
    assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_mp_fifo.sv
// Directed self-checking bench for mp_fifo (WIDTH=32 DEPTH=8 NUM_PUSH=2 NUM_POP=2).
module tb_mp_fifo;
    localparam int WIDTH    = 32;
    localparam int DEPTH    = 8;
    localparam int NUM_PUSH = 2;
    localparam int NUM_POP  = 2;
`ifdef MP_FIFO_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    logic [31:0] exp_q [$];

    mp_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_PUSH(NUM_PUSH), .NUM_POP(NUM_POP)) bus ();

    mp_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_PUSH(NUM_PUSH), .NUM_POP(NUM_POP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] pe, input logic [31:0] d1, input logic [31:0] d0,
                         input logic [1:0] oe, input logic fl);
        bus.push_en   = pe;
        bus.push_data = {d1, d0};
        bus.pop_en    = oe;
        bus.flush     = fl;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        drive(2'b00, 32'h0, 32'h0, 2'b00, 1'b0);
        #12;
        check("rst_count",      64'(bus.count),      64'd0);
        check("rst_pop_valid",  64'(bus.pop_valid),  64'b00);
        check("rst_push_ready", 64'(bus.push_ready), 64'b11);
        check("rst_err",        64'(bus.err),        64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Fill with 0x1..0x8, two per cycle.
        for (int k = 0; k < 4; k++) begin
            drive(2'b11, 32'(2*k+2), 32'(2*k+1), 2'b00, 1'b0);
            step();
        end
        drive(2'b00, 32'h0, 32'h0, 2'b00, 1'b0);
        check("full_count",      64'(bus.count),      64'd8);
        check("full_push_ready", 64'(bus.push_ready), 64'b00);
        check("full_pop_valid",  64'(bus.pop_valid),  64'b11);
        check("full_pop_data",   bus.pop_data,        {32'h2, 32'h1});

        // From full: the push is refused because readiness comes from the old count.
        drive(2'b11, 32'hBB, 32'hAA, 2'b11, 1'b0);
        step();
        drive(2'b00, 32'h0, 32'h0, 2'b00, 1'b0);
        check("fullpp_count",      64'(bus.count),      64'd6);
        check("fullpp_pop_data",   bus.pop_data,        {32'h4, 32'h3});
        check("fullpp_push_ready", 64'(bus.push_ready), 64'b11);
        for (int v = 3; v <= 8; v++) exp_q.push_back(32'(v));

        // Sustained push 2 / pop 2 across pointer wrap.
        for (int k = 0; k < 10; k++) begin
            drive(2'b11, 32'(10 + 2*k), 32'(9 + 2*k), 2'b11, 1'b0);
            check($sformatf("wrap_data_%0d", k), bus.pop_data, {exp_q[1], exp_q[0]});
            step();
            void'(exp_q.pop_front());
            void'(exp_q.pop_front());
            exp_q.push_back(32'(9 + 2*k));
            exp_q.push_back(32'(10 + 2*k));
            check($sformatf("wrap_count_%0d", k), 64'(bus.count), 64'd6);
        end

        // Drain down to a single entry.
        drive(2'b00, 32'h0, 32'h0, 2'b11, 1'b0);
        step();
        step();
        void'(exp_q.pop_front()); void'(exp_q.pop_front());
        void'(exp_q.pop_front()); void'(exp_q.pop_front());
        drive(2'b00, 32'h0, 32'h0, 2'b01, 1'b0);
        step();
        void'(exp_q.pop_front());
        check("one_count",     64'(bus.count),               64'd1);
        check("one_pop_valid", 64'(bus.pop_valid),           64'b01);
        check("one_pop_data",  64'(bus.pop_data[31:0]),      64'(exp_q[0]));

        // Pop two with only one valid: only lane 0 is taken.
        drive(2'b00, 32'h0, 32'h0, 2'b11, 1'b0);
        step();
        check("under_count",     64'(bus.count),     64'd0);
        check("under_pop_valid", 64'(bus.pop_valid), 64'b00);

        // Push into empty FIFO: no bypass, visible next cycle; pop on empty is ignored.
        drive(2'b01, 32'h0, 32'h55, 2'b01, 1'b0);
        #1;
        check("nobypass_pop_valid", 64'(bus.pop_valid), 64'b00);
        step();
        drive(2'b00, 32'h0, 32'h0, 2'b00, 1'b0);
        check("empty_push_count",     64'(bus.count),          64'd1);
        check("empty_push_pop_valid", 64'(bus.pop_valid),      64'b01);
        check("empty_push_pop_data",  64'(bus.pop_data[31:0]), 64'h55);

        // Build to five entries then flush alongside a push and pop.
        drive(2'b11, 32'h62, 32'h61, 2'b00, 1'b0);
        step();
        drive(2'b11, 32'h64, 32'h63, 2'b00, 1'b0);
        step();
        check("pre_flush_count", 64'(bus.count), 64'd5);
        drive(2'b11, 32'h66, 32'h65, 2'b11, 1'b1);
        step();
        drive(2'b00, 32'h0, 32'h0, 2'b00, 1'b0);
        check("flush_count",      64'(bus.count),      64'd0);
        check("flush_pop_valid",  64'(bus.pop_valid),  64'b00);
        check("flush_push_ready", 64'(bus.push_ready), 64'b11);
        step();
        check("flush_idle_count", 64'(bus.count), 64'd0);

        // Non-contiguous push on empty: the one enabled lane is accepted.
        drive(2'b10, 32'h77, 32'h0, 2'b00, 1'b0);
        step();
        drive(2'b00, 32'h0, 32'h0, 2'b00, 1'b0);
        check("gap_count", 64'(bus.count), 64'd1);
        check("gap_err",   64'(bus.err),   64'(ERR_EN));
        drive(2'b00, 32'h0, 32'h0, 2'b00, 1'b1);
        step();
        drive(2'b00, 32'h0, 32'h0, 2'b00, 1'b0);
        check("gap_flush_count", 64'(bus.count), 64'd0);
        check("gap_flush_err",   64'(bus.err),   64'(ERR_EN));

        // Asynchronous reset mid-cycle with data present.
        drive(2'b11, 32'h82, 32'h81, 2'b00, 1'b0);
        step();
        drive(2'b00, 32'h0, 32'h0, 2'b00, 1'b0);
        check("pre_arst_count", 64'(bus.count), 64'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_count",      64'(bus.count),      64'd0);
        check("arst_pop_valid",  64'(bus.pop_valid),  64'b00);
        check("arst_push_ready", 64'(bus.push_ready), 64'b11);
        check("arst_err",        64'(bus.err),        64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("post_arst_count", 64'(bus.count), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
